i2c_scl_gen: RTL and testbench

- Parametrised SCL timing generator; successor to the fixed 400 kHz divider.
- Produces a four-phase SCL waveform with a runtime-programmable quarter-period.
- Emits single-cycle phase ticks (fall, low-mid, rise, high-mid) for the I2C master FSM.
- Supports slave clock stretching, plus a clean start/stop controlled by an enable.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/i2c_scl_gen.sv | 175 +++++++++++++++++
 tb/tb_i2c_scl_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C clock generator and master.
package i2c_pkg;

  // SCL phases; IDLE means SCL released and no period in progress
  typedef enum logic [2:0] {
    IDLE,
    LOW_A,
    LOW_B,
    HIGH_A,
    HIGH_B
  } scl_phase_t;

  // Smallest usable quarter-period; shorter values cannot form four phases
  localparam int Q_MIN = 2;

  // Quarter-period in clk cycles for a requested SCL frequency
  function automatic int calc_q(input int clk_hz, input int scl_hz);
    return clk_hz / (4 * scl_hz);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw input through the flop chain; reset to the idle bus level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_scl_gen.sv
// Four-phase SCL generator with programmable quarter-period, phase ticks
// for the master FSM, slave clock stretching and graceful enable/disable.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCL_HZ      = 400_000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] q_div,
  input  logic             q_load,
  input  logic             scl_in,
  output logic             scl_low,
  output logic             tick_fall,
  output logic             tick_low_mid,
  output logic             tick_rise,
  output logic             tick_high_mid,
  output logic             busy,
  output logic             stretching
);

  localparam int               DEFAULT_Q   = calc_q(CLK_HZ, SCL_HZ);
  localparam logic [CNT_W-1:0] DEFAULT_Q_W = CNT_W'(DEFAULT_Q);
  localparam logic [CNT_W-1:0] Q_MIN_W     = CNT_W'(Q_MIN);
  localparam logic [CNT_W-1:0] SYNC_W      = CNT_W'(SYNC_STAGES);

  // Quarter-periods below the minimum are raised to it
  function automatic logic [CNT_W-1:0] clamp_q(input logic [CNT_W-1:0] q);
    return (q < Q_MIN_W) ? Q_MIN_W : q;
  endfunction

  scl_phase_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_pending_q, r_active_q;
  logic             r_stretch, w_stretch_nxt;
  logic             w_load_active;
  logic             r_tick_fall, r_tick_low_mid, r_tick_rise, r_tick_high_mid;
  logic             w_tick_fall, w_tick_low_mid, w_tick_rise, w_tick_high_mid;
  logic             w_scl_s;
  logic             w_last;
  logic             w_blind;

  sync_2ff #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b1)
  ) u_scl_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (scl_in),
    .o_q  (w_scl_s)
  );

  assign w_last  = (r_cnt == r_active_q - CNT_W'(1));
  // Our own release needs SYNC_STAGES cycles to appear on w_scl_s, so the
  // first cycles of HIGH_A count unconditionally instead of looking like a stretch.
  assign w_blind = (r_state == HIGH_A) && !r_stretch && (r_cnt < SYNC_W);

  // Next-state, counter and tick decode for the four SCL phases
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_stretch_nxt   = r_stretch;
    w_load_active   = 1'b0;
    w_tick_fall     = 1'b0;
    w_tick_low_mid  = 1'b0;
    w_tick_rise     = 1'b0;
    w_tick_high_mid = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt   = LOW_A;
          w_cnt_nxt     = '0;
          w_load_active = 1'b1;
          w_tick_fall   = 1'b1;
        end
      end
      LOW_A: begin
        if (w_last) begin
          w_state_nxt    = LOW_B;
          w_cnt_nxt      = '0;
          w_tick_low_mid = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      LOW_B: begin
        if (w_last) begin
          w_state_nxt   = HIGH_A;
          w_cnt_nxt     = '0;
          w_stretch_nxt = 1'b0;
          w_tick_rise   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HIGH_A: begin
        if (w_blind || w_scl_s) begin
          if (w_last) begin
            w_state_nxt     = HIGH_B;
            w_cnt_nxt       = '0;
            w_stretch_nxt   = 1'b0;
            w_tick_high_mid = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          // Slave holds SCL low: restart the high time from the observed rise
          w_cnt_nxt     = '0;
          w_stretch_nxt = 1'b1;
        end
      end
      HIGH_B: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (en) begin
            w_state_nxt   = LOW_A;
            w_load_active = 1'b1;
            w_tick_fall   = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter, divider registers and registered tick pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_pending_q     <= DEFAULT_Q_W;
      r_active_q      <= DEFAULT_Q_W;
      r_stretch       <= 1'b0;
      r_tick_fall     <= 1'b0;
      r_tick_low_mid  <= 1'b0;
      r_tick_rise     <= 1'b0;
      r_tick_high_mid <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_stretch       <= w_stretch_nxt;
      r_tick_fall     <= w_tick_fall;
      r_tick_low_mid  <= w_tick_low_mid;
      r_tick_rise     <= w_tick_rise;
      r_tick_high_mid <= w_tick_high_mid;
      if (q_load) begin
        r_pending_q <= q_div;
      end
      // Period start copies the value pending before any same-edge load
      if (w_load_active) begin
        r_active_q <= clamp_q(r_pending_q);
      end
    end
  end

  assign scl_low       = (r_state == LOW_A) || (r_state == LOW_B);
  assign busy          = (r_state != IDLE);
  assign stretching    = (r_state == HIGH_A) && !w_blind && !w_scl_s;
  assign tick_fall     = r_tick_fall;
  assign tick_low_mid  = r_tick_low_mid;
  assign tick_rise     = r_tick_rise;
  assign tick_high_mid = r_tick_high_mid;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Scoreboard bench for i2c_scl_gen: the driver predicts tick times per period
// from quarter-period arithmetic, a monitor pops and compares on every tick.
module tb_i2c_scl_gen;

  localparam int SYNC = 2;
  localparam int DQ   = 62;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] q_div = '0;
  logic        q_load = 1'b0;
  logic        scl_in;
  logic        scl_low, tick_fall, tick_low_mid, tick_rise, tick_high_mid;
  logic        busy, stretching;
  logic        force_low = 1'b0;

  i2c_scl_gen #(
    .CLK_HZ(100_000_000), .SCL_HZ(400_000), .CNT_W(16), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .q_div(q_div), .q_load(q_load),
    .scl_in(scl_in), .scl_low(scl_low), .tick_fall(tick_fall),
    .tick_low_mid(tick_low_mid), .tick_rise(tick_rise),
    .tick_high_mid(tick_high_mid), .busy(busy), .stretching(stretching)
  );

  // Open-drain bus: low if we drive it or a slave holds it
  assign scl_in = ~scl_low & ~force_low;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   kind;  // 0 fall, 1 low_mid, 2 rise, 3 high_mid
    int   cyc;
    logic sl;
    int   sc;    // stretching cycles expected before high_mid
  } ev_t;

  ev_t evq[$];
  int  total = 0;
  int  bad = 0;
  int  pend;
  int  q_cur;
  int  cur_T;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int clampq(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic void push(input int k, input int c, input logic sl, input int sc);
    ev_t e;
    e.kind = k; e.cyc = c; e.sl = sl; e.sc = sc;
    evq.push_back(e);
  endfunction

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: compare every tick against the oldest prediction
  initial begin
    int   scnt;
    int   nt;
    int   kind;
    ev_t  e;
    scnt = 0;
    forever begin
      @(negedge clk);
      nt = int'(tick_fall) + int'(tick_low_mid) + int'(tick_rise) + int'(tick_high_mid);
      if (tick_rise) scnt = 0;
      if (stretching) scnt++;
      if (nt > 1) chk("ticks_onehot", nt, 1);
      if (nt == 1) begin
        kind = tick_fall ? 0 : tick_low_mid ? 1 : tick_rise ? 2 : 3;
        if (evq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_tick kind=%0d at cycle %0d: got a tick, want none", kind, cyc);
        end else begin
          e = evq.pop_front();
          chk("tick_kind", kind, e.kind);
          chk("tick_cycle", cyc, e.cyc);
          chk("scl_low_at_tick", scl_low, e.sl);
          chk("busy_at_tick", busy, 1);
          if (kind == 3) chk("stretch_cycles", scnt, e.sc);
        end
      end
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        total++; bad++;
        $display("FAIL missed_tick kind=%0d: got none by cycle %0d, want at cycle %0d", e.kind, cyc, e.cyc);
      end
    end
  end

  // Raise en from IDLE; first period starts one cycle later
  task automatic start();
    chk("idle_busy_before_en", busy, 0);
    en = 1'b1;
    q_cur = clampq(pend);
    cur_T = cyc + 1;
    push(0, cur_T, 1'b1, 0);
    @(negedge clk);
    chk("restart_busy", busy, 1);
    chk("restart_scl_low", scl_low, 1);
  endtask

  // One SCL period starting at cur_T; lo=-1 no load, -2 load on the start edge, else offset
  task automatic period(input int h, input int lo, input int lv, input bit stop);
    int q, x, tn, qn;
    q  = q_cur;
    x  = (h > 0) ? h + SYNC : 0;
    tn = cur_T + 4 * q + x;
    push(1, cur_T + q, 1'b1, 0);
    push(2, cur_T + 2 * q, 1'b0, 0);
    push(3, cur_T + 3 * q + x, 1'b0, h);
    if (lo >= 0) begin
      wait_until(cur_T + lo);
      q_div = 16'(lv); q_load = 1'b1;
      @(negedge clk);
      q_load = 1'b0;
      pend = lv;
    end
    if (stop) begin
      wait_until(cur_T + q + 1);
      en = 1'b0;
    end
    if (h > 0) begin
      wait_until(cur_T + 2 * q);
      force_low = 1'b1;
      wait_until(cur_T + 2 * q + h);
      force_low = 1'b0;
    end
    wait_until(tn - 1);
    qn = clampq(pend);
    if (lo == -2) begin
      q_div = 16'(lv); q_load = 1'b1;
      pend = lv;
    end
    if (!stop) push(0, tn, 1'b1, 0);
    else chk("busy_last_cycle", busy, 1);
    @(negedge clk);
    q_load = 1'b0;
    if (stop) begin
      chk("stop_busy", busy, 0);
      chk("stop_scl_low", scl_low, 0);
    end else begin
      q_cur = qn;
      cur_T = tn;
    end
  endtask

  // Driver
  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_scl_low", scl_low, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ticks", int'(tick_fall) + int'(tick_low_mid) + int'(tick_rise) + int'(tick_high_mid), 0);
    chk("reset_stretching", stretching, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_scl_low", scl_low, 0);
    pend = DQ;

    // default run, then a 100-cycle stretch
    start();
    period(0, -1, 0, 0);
    period(0, -1, 0, 0);
    period(100, -1, 0, 0);

    // divider change mid-period, then clamp of 0
    period(0, 30, 10, 0);
    period(0, -1, 0, 0);
    period(0, 3, 0, 0);
    period(0, -1, 0, 0);

    // randomized periods
    repeat (25) begin
      int h, lo, lv, r;
      h  = (q_cur >= 3 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      r  = $urandom_range(0, 3);
      lv = $urandom_range(0, 24);
      lo = (r == 0) ? -1 : (r == 1) ? -2 : int'($urandom_range(0, 2 * q_cur - 1));
      period(h, lo, lv, 1'b0);
    end

    // graceful stop with a known divider, idle, restart
    period(0, 5, 20, 0);
    period(0, -1, 0, 1);
    repeat (20) @(negedge clk);
    chk("idle_after_stop_busy", busy, 0);
    start();

    // reset during LOW_A with en held high
    wait_until(cur_T + $urandom_range(1, q_cur - 2));
    rst_n = 1'b0;
    @(negedge clk);
    evq.delete();
    chk("midreset_scl_low", scl_low, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_ticks", int'(tick_fall) + int'(tick_low_mid) + int'(tick_rise) + int'(tick_high_mid), 0);
    rst_n = 1'b1;
    pend  = DQ;
    q_cur = DQ;
    cur_T = cyc + 1;
    push(0, cur_T, 1'b1, 0);
    @(negedge clk);
    period(0, -1, 0, 0);
    period(0, -1, 0, 1);

    // drain any outstanding predictions
    begin
      int budget;
      budget = 0;
      while (evq.size() > 0 && budget < 2000) begin
        @(negedge clk);
        budget++;
      end
      if (evq.size() > 0) chk("drain_timeout", evq.size(), 0);
    end
    repeat (5) @(negedge clk);
    chk("final_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hang guard
  initial begin
    #800000;
    $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
